// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port, combinational-read word memory between the RV32I
// instruction-fetch requester (i_*) and the load/store requester (d_*).
// Data wins ties, but a fetch that has been denied STARVE_LIMIT cycles in a
// row wins the next tie. Partial stores (0 < d_be < 4'hF) are expanded into
// a read cycle followed by a merged write cycle (RMW_WR). Responses are
// registered and arrive one cycle after the grant, or two cycles for a
// partial store.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   i_req/i_addr        fetch request and byte address
//   i_gnt               fetch accepted this cycle (combinational)
//   i_rvalid/i_rdata    fetch response pulse and fetched word
//   i_err               fetch address misaligned (qualified by i_rvalid)
//   d_req/d_we/d_be     data request, store flag, store byte enables
//   d_addr/d_wdata      data byte address, store data (lane aligned)
//   d_gnt               data accepted this cycle (combinational)
//   d_rvalid/d_rdata    data response pulse, load word (0 for stores)
//   d_err               data address misaligned (qualified by d_rvalid)
//   mem_addr/mem_wdata  memory address and write data
//   mem_we              memory write enable
//   mem_rdata           memory combinational read data
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_RMW_WR = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             i_rvalid_q, i_rvalid_d;
    logic             i_err_q, i_err_d;
    logic [31:0]      i_rdata_q, i_rdata_d;
    logic             d_rvalid_q, d_rvalid_d;
    logic             d_err_q, d_err_d;
    logic [31:0]      d_rdata_q, d_rdata_d;
    logic [31:0]      merge_q, merge_d;
    logic [31:0]      rmw_addr_q, rmw_addr_d;
    logic [3:0]       rmw_be_q, rmw_be_d;
    logic [31:0]      rmw_wdata_q, rmw_wdata_d;

    logic i_mis, d_mis, d_full, d_partial, starved;

    assign i_mis     = |i_addr[1:0];
    assign d_mis     = |d_addr[1:0];
    assign d_full    = (d_be == 4'hF);
    assign d_partial = !d_full && (|d_be);
    assign starved   = (cnt_q >= CNT_LIMIT);

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_d     = state_q;
        i_rvalid_d  = 1'b0;
        i_err_d     = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rvalid_d  = 1'b0;
        d_err_d     = 1'b0;
        d_rdata_d   = d_rdata_q;
        merge_d     = merge_q;
        rmw_addr_d  = rmw_addr_q;
        rmw_be_d    = rmw_be_q;
        rmw_wdata_d = rmw_wdata_q;
        i_gnt       = 1'b0;
        d_gnt       = 1'b0;
        mem_addr    = i_addr;
        mem_wdata   = 32'h0;
        mem_we      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // rst_n gating keeps grants (and hence writes) low while the
                // flops are held in reset.
                if (rst_n) begin
                    if (d_req && !(i_req && starved)) begin
                        d_gnt = 1'b1;
                    end else if (i_req) begin
                        i_gnt = 1'b1;
                    end
                end

                if (d_gnt) begin
                    mem_addr   = d_addr;
                    d_rvalid_d = 1'b1;
                    d_err_d    = d_mis;
                    d_rdata_d  = 32'h0;
                    if (!d_mis) begin
                        if (!d_we) begin
                            d_rdata_d = mem_rdata;
                        end else if (d_full) begin
                            mem_we    = 1'b1;
                            mem_wdata = d_wdata;
                        end else if (d_partial) begin
                            // Read half of the RMW: the response moves to
                            // the cycle after the merged write.
                            d_rvalid_d  = 1'b0;
                            merge_d     = mem_rdata;
                            rmw_addr_d  = d_addr;
                            rmw_be_d    = d_be;
                            rmw_wdata_d = d_wdata;
                            state_d     = ST_RMW_WR;
                        end
                    end
                end

                if (i_gnt) begin
                    i_rvalid_d = 1'b1;
                    i_err_d    = i_mis;
                    i_rdata_d  = i_mis ? 32'h0 : mem_rdata;
                end
            end

            default: begin // ST_RMW_WR
                mem_addr = rmw_addr_q;
                mem_we   = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    mem_wdata[8*k +: 8] = rmw_be_q[k] ? rmw_wdata_q[8*k +: 8]
                                                      : merge_q[8*k +: 8];
                end
                d_rvalid_d = 1'b1;
                d_rdata_d  = 32'h0;
                state_d    = ST_IDLE;
            end
        endcase

        if (i_req && !i_gnt) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
        end
    end

    // NOTE: the RMW capture registers are reset along with everything else;
    // they are tiny, and a known value keeps mem_wdata deterministic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            i_rvalid_q  <= 1'b0;
            i_err_q     <= 1'b0;
            i_rdata_q   <= 32'h0;
            d_rvalid_q  <= 1'b0;
            d_err_q     <= 1'b0;
            d_rdata_q   <= 32'h0;
            merge_q     <= 32'h0;
            rmw_addr_q  <= 32'h0;
            rmw_be_q    <= 4'h0;
            rmw_wdata_q <= 32'h0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of its _d, independent of statement order.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            i_rvalid_q  <= i_rvalid_d;
            i_err_q     <= i_err_d;
            i_rdata_q   <= i_rdata_d;
            d_rvalid_q  <= d_rvalid_d;
            d_err_q     <= d_err_d;
            d_rdata_q   <= d_rdata_d;
            merge_q     <= merge_d;
            rmw_addr_q  <= rmw_addr_d;
            rmw_be_q    <= rmw_be_d;
            rmw_wdata_q <= rmw_wdata_d;
        end
    end

    assign i_rvalid = i_rvalid_q;
    assign i_err    = i_err_q;
    assign i_rdata  = i_rdata_q;
    assign d_rvalid = d_rvalid_q;
    assign d_err    = d_err_q;
    assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Bench for mem_port_arbiter. A 64-word memory sits on the mem_* port. A
// transaction-level model (golden memory, denied-cycle count, expected
// response slots) predicts grants, writes and responses; one negedge process
// compares the DUT against it every cycle. Directed stimulus adds literal
// expectations that pin the model.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = 32'h0;
    logic        i_gnt, i_rvalid, i_err;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_be = 4'h0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_err(d_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    // Memory attached to the DUT.
    logic [31:0] env_mem [0:63];
    assign mem_rdata = env_mem[mem_addr[7:2]];
    always @(posedge clk) if (mem_we) env_mem[mem_addr[7:2]] = mem_wdata;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed { logic v; logic err; logic [31:0] data; } resp_t;
    typedef struct packed { logic v; logic [31:0] addr; logic [31:0] data; } wr_t;

    logic [31:0] ref_mem [0:63];
    resp_t i_slot;          // expected fetch response for the current cycle
    resp_t d_slot [0:1];    // expected data responses: current cycle, next
    wr_t   wr_slot;         // expected RMW write for the current cycle
    int    starve = 0;      // consecutive cycles fetch was requesting and denied
    bit    busy = 1'b0;     // current cycle is the write half of a partial store

    bit          log_en = 1'b0;
    logic [1:0]  glog [$];

    function automatic resp_t mk(input logic v, input logic err, input logic [31:0] data);
        resp_t r;
        r.v = v; r.err = err; r.data = data;
        return r;
    endfunction

    always @(negedge clk) begin : cmp
        logic        eg_d, eg_i, exp_we;
        logic [31:0] merged, word;
        if (!rst_n) begin
            check("rst_i_gnt", i_gnt, 0);
            check("rst_d_gnt", d_gnt, 0);
            check("rst_mem_we", mem_we, 0);
            check("rst_i_rvalid", i_rvalid, 0);
            check("rst_d_rvalid", d_rvalid, 0);
            check("rst_i_err", i_err, 0);
            check("rst_d_err", d_err, 0);
            check("rst_i_rdata", i_rdata, 0);
            check("rst_d_rdata", d_rdata, 0);
            i_slot = '0; d_slot[0] = '0; d_slot[1] = '0; wr_slot = '0;
            starve = 0; busy = 1'b0;
        end else begin
            eg_d = 1'b0; eg_i = 1'b0;
            if (!busy) begin
                if (d_req && !(i_req && starve >= 4)) eg_d = 1'b1;
                else if (i_req) eg_i = 1'b1;
            end
            check("i_gnt", i_gnt, eg_i);
            check("d_gnt", d_gnt, eg_d);
            if (log_en) glog.push_back({d_gnt, i_gnt});

            check("i_rvalid", i_rvalid, i_slot.v);
            if (i_slot.v) begin
                check("i_err", i_err, i_slot.err);
                check("i_rdata", i_rdata, i_slot.data);
            end
            check("d_rvalid", d_rvalid, d_slot[0].v);
            if (d_slot[0].v) begin
                check("d_err", d_err, d_slot[0].err);
                check("d_rdata", d_rdata, d_slot[0].data);
            end

            exp_we = wr_slot.v ||
                     (eg_d && d_we && d_be == 4'hF && d_addr[1:0] == 2'b00);
            check("mem_we", mem_we, exp_we);
            if (wr_slot.v) begin
                check("rmw_addr", mem_addr, wr_slot.addr);
                check("rmw_wdata", mem_wdata, wr_slot.data);
                ref_mem[wr_slot.addr[7:2]] = wr_slot.data;
            end
            if (eg_d) check("d_mem_addr", mem_addr, d_addr);
            if (eg_i) check("i_mem_addr", mem_addr, i_addr);

            // Advance to the next cycle and schedule new expectations.
            i_slot = '0; d_slot[0] = d_slot[1]; d_slot[1] = '0; wr_slot = '0;
            busy = 1'b0;
            if (eg_i) begin
                if (i_addr[1:0] != 2'b00) i_slot = mk(1'b1, 1'b1, 32'h0);
                else i_slot = mk(1'b1, 1'b0, ref_mem[i_addr[7:2]]);
            end
            if (eg_d) begin
                word = ref_mem[d_addr[7:2]];
                if (d_addr[1:0] != 2'b00) begin
                    d_slot[0] = mk(1'b1, 1'b1, 32'h0);
                end else if (!d_we) begin
                    d_slot[0] = mk(1'b1, 1'b0, word);
                end else if (d_be == 4'hF) begin
                    ref_mem[d_addr[7:2]] = d_wdata;
                    d_slot[0] = mk(1'b1, 1'b0, 32'h0);
                end else if (d_be == 4'h0) begin
                    d_slot[0] = mk(1'b1, 1'b0, 32'h0);
                end else begin
                    for (int k = 0; k < 4; k++)
                        merged[8*k +: 8] = d_be[k] ? d_wdata[8*k +: 8] : word[8*k +: 8];
                    wr_slot.v = 1'b1; wr_slot.addr = d_addr; wr_slot.data = merged;
                    d_slot[1] = mk(1'b1, 1'b0, 32'h0);
                    busy = 1'b1;
                end
            end
            if (i_req && !eg_i) starve = (starve < 7) ? starve + 1 : 7;
            else starve = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_gnt(input bit is_d);
        int n;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (is_d ? d_gnt : i_gnt) break;
        end
        if (n == 20) begin
            checks++; errors++;
            $display("FAIL grant_timeout: no %s grant within 20 cycles", is_d ? "data" : "fetch");
        end
    endtask

    task automatic i_op(input logic [31:0] addr);
        @(posedge clk); #1;
        i_addr = addr; i_req = 1'b1;
        wait_gnt(1'b0);
        @(posedge clk); #1;
        i_req = 1'b0;
    endtask

    task automatic d_op(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata);
        @(posedge clk); #1;
        d_we = we; d_be = be; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
        wait_gnt(1'b1);
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        logic [1:0] exp_pat [0:9];
        exp_pat = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};

        for (int w = 0; w < 64; w++) begin
            env_mem[w] = 32'h0101_0101 * w;
            ref_mem[w] = 32'h0101_0101 * w;
        end
        env_mem[4] = 32'hDEAD_BEEF; ref_mem[4] = 32'hDEAD_BEEF;
        env_mem[3] = 32'hAAAA_AAAA; ref_mem[3] = 32'hAAAA_AAAA;

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Fetch of word 4.
        i_op(32'h10);
        @(negedge clk);
        check("fetch_rvalid", i_rvalid, 1);
        check("fetch_rdata", i_rdata, 32'hDEAD_BEEF);
        check("fetch_err", i_err, 0);

        // Full store then load back.
        d_op(1'b1, 4'hF, 32'h08, 32'h1234_5678);
        d_op(1'b0, 4'h0, 32'h08, 32'h0);
        @(negedge clk);
        check("load_rvalid", d_rvalid, 1);
        check("load_rdata", d_rdata, 32'h1234_5678);

        // Partial store into byte lane 1.
        d_op(1'b1, 4'b0010, 32'h08, 32'h0000_AB00);
        @(negedge clk);
        check("rmw_we_in_wr", mem_we, 1);
        check("rmw_no_gnt", d_gnt, 0);
        check("rmw_no_early_rsp", d_rvalid, 0);
        @(negedge clk);
        check("rmw_rvalid", d_rvalid, 1);
        check("rmw_word", env_mem[2], 32'h1234_AB78);

        // Store with no byte enables: no write, still answered.
        d_op(1'b1, 4'h0, 32'h08, 32'hFFFF_FFFF);
        @(negedge clk);
        check("be0_rvalid", d_rvalid, 1);

        // Misaligned load and store.
        d_op(1'b0, 4'h0, 32'h06, 32'h0);
        @(negedge clk);
        check("mis_load_err", d_err, 1);
        check("mis_load_rdata", d_rdata, 0);
        d_op(1'b1, 4'hF, 32'h0A, 32'hFFFF_FFFF);
        @(negedge clk);
        check("mis_store_err", d_err, 1);
        check("mis_store_word", env_mem[2], 32'h1234_AB78);

        // Misaligned fetch.
        i_op(32'h12);
        @(negedge clk);
        check("mis_fetch_err", i_err, 1);
        check("mis_fetch_rdata", i_rdata, 0);

        // Both requesters held: four data grants, then one fetch grant.
        @(posedge clk); #1;
        i_addr = 32'h10; d_we = 1'b0; d_addr = 32'h08; d_be = 4'h0;
        i_req = 1'b1; d_req = 1'b1; log_en = 1'b1;
        repeat (10) @(posedge clk);
        #1 i_req = 1'b0; d_req = 1'b0; log_en = 1'b0;
        check("starve_log_len", glog.size(), 10);
        for (int c = 0; c < 10 && c < glog.size(); c++)
            check($sformatf("starve_pat_%0d", c), glog[c], exp_pat[c]);

        // Reset during RMW_WR aborts the write and its response.
        @(posedge clk); #1;
        d_we = 1'b1; d_be = 4'b0001; d_addr = 32'h0C; d_wdata = 32'h0000_0055; d_req = 1'b1;
        wait_gnt(1'b1);
        @(posedge clk); #1;
        d_req = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        check("abort_we", mem_we, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("abort_no_rsp", d_rvalid, 0);
        end
        check("abort_word", env_mem[3], 32'hAAAA_AAAA);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port word memory between the instruction-fetch requester and the load/store requester of the RV32I core.
- Performs fixed-priority arbitration with an anti-starvation counter, and expands byte-enabled (partial) stores into a read-modify-write sequence.
- Returns registered responses.
- Sits between the core's fetch/LSU stages and the memory block. It drives that block's address, write_data and write_enable, and consumes its combinational read_data.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles the fetch requester may be denied while requesting before it wins priority.
- CNT_W, 3: width of the starvation counter. Must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  fetch request, held until granted
- i_addr  in  32  fetch byte address
- i_gnt  out  1  fetch accepted this cycle (combinational)
- i_rvalid  out  1  fetch response valid, 1-cycle pulse
- i_rdata  out  32  fetched word
- i_err  out  1  fetch misaligned, qualified by i_rvalid
- d_req  in  1  data request, held until granted
- d_we  in  1  1 = store, 0 = load
- d_be  in  4  byte enables for stores; ignored for loads
- d_addr  in  32  data byte address
- d_wdata  in  32  store data, byte lanes aligned to d_be
- d_gnt  out  1  data accepted this cycle (combinational)
- d_rvalid  out  1  data response valid, 1-cycle pulse
- d_rdata  out  32  load word; 0 for stores
- d_err  out  1  misaligned, qualified by d_rvalid
- mem_addr  out  32  to memory address
- mem_wdata  out  32  to memory write_data
- mem_we  out  1  to memory write_enable
- mem_rdata  in  32  from memory read_data (combinational read)

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0:
  - state=IDLE, starvation counter=0;
  - i_rvalid, d_rvalid, i_err, d_err = 0;
  - i_rdata, d_rdata = 0;
  - merge register = 0.
- mem_we, i_gnt and d_gnt decode combinationally from state and are forced 0 during reset.
- States:
  - IDLE: arbitrate; at most one grant per cycle.
  - RMW_WR: second cycle of a partial store; no grants.
- Arbitration in IDLE:
  - Only d_req: grant data.
  - Only i_req: grant fetch.
  - Both requesting: grant data, unless the counter is ≥ STARVE_LIMIT, in which case grant fetch.
- Starvation counter:
  - Increments (saturating) each cycle i_req=1 and i_gnt=0.
  - Clears on i_gnt or when i_req=0.
- mem_addr:
  - Follows the granted request's address.
  - Holds the latched store address in RMW_WR.
  - Otherwise equals i_addr.
- mem_wdata = 0 and mem_we = 0 unless stated below.
- Fetch grant: i_rdata <= mem_rdata at the next edge; i_rvalid=1 for exactly one cycle after i_gnt (latency 1).
- Load grant: d_rdata <= mem_rdata at the next edge; d_rvalid one cycle after d_gnt.
- Store with d_be=4'hF:
  - In the grant cycle, mem_we=1 and mem_wdata=d_wdata.
  - d_rvalid the next cycle, d_rdata=0.
- Store with d_be≠4'hF and d_be≠0:
  - Grant cycle: mem_we=0; capture addr, be and wdata; merge register <= mem_rdata; go to RMW_WR.
  - RMW_WR: mem_we=1; mem_wdata per byte lane k = be[k] ? wdata lane k : merge lane k.
  - The cycle after RMW_WR: return to IDLE and pulse d_rvalid.
  - Total 2 cycles occupied; the response arrives 2 cycles after d_gnt.
- Store with d_be=0: treated as a no-op. Granted, no write, d_rvalid the next cycle.
- Misaligned access (addr[1:0]≠0):
  - Still granted.
  - Never writes: mem_we=0, no RMW.
  - Response next cycle with err=1 and rdata=0.
- The requester must not change addr/we/be/wdata while req=1 and not granted. Deassertion before grant is legal and withdraws the request.
- Response pulses: a given pulse occurs for one requester at a time. A fetch response and a data response can never be valid in the same cycle, since only one grant is issued per cycle.
- Reset asserted in RMW_WR aborts the write: no mem_we, no response after reset release.
- The address is passed through unmodified. Bounds and wrap-around are the memory's concern.

Test Plan:
- Reset, then i_req=1 with i_addr=0x10, mem word 4 = 0xDEADBEEF → i_gnt in same cycle, i_rvalid next cycle, i_rdata=0xDEADBEEF, i_err=0.
- d_req store d_be=F, addr=0x08, wdata=0x12345678; then load 0x08 → mem_we for one cycle; load returns 0x12345678, d_rvalid latency 1.
- Word 0x08=0x12345678, store d_be=4'b0010, wdata=0x0000AB00 → exactly one mem_we cycle, in RMW_WR; word becomes 0x1234AB78; d_rvalid 2 cycles after d_gnt; no grant during RMW_WR.
- i_req and d_req held high continuously, STARVE_LIMIT=4 → data granted 4 consecutive cycles, fetch granted on 5th, counter clears, pattern repeats.
- Load addr=0x06; store addr=0x0A with be=F → d_err=1, d_rdata=0; memory word unchanged, mem_we never high.
- Partial store granted, rst_n pulled low during RMW_WR → mem_we=0 immediately, outputs at reset values, target word unchanged, no d_rvalid after release.
